// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes and
// the datapath select/strobe values it drives.
package riscv_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_LUI      = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // What the current state asks of the ALU: fixed add/sub, or a funct decode.
  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_R,
    ALU_CLS_I
  } alu_class_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from the state class and latched funct bits.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3)
          // Only register-register ops use bit 30 to select subtract.
          3'b000:  alu_control = (alu_class == ALU_CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle RV32I datapath; the BRANCH PCWrite is
// the single Zero-dependent output.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUSrcA,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  logic [3:0]       state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             funct7b5_q, funct7b5_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  alu_class_e       alu_class;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (op_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI:         state_d = S_ALUWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // Instruction fields are only trusted while IR is being loaded.
  always_comb begin
    op_d       = (state_q == S_FETCH) ? op       : op_q;
    funct3_d   = (state_q == S_FETCH) ? funct3   : funct3_q;
    funct7b5_d = (state_q == S_FETCH) ? funct7b5 : funct7b5_q;
    illegal_d  = illegal_q | (state_d == S_ILLEGAL);
    retire     = (state_d == S_FETCH) &&
                 ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BRANCH));
    retired_d  = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    ImmSrc    = IMM_I;
    alu_class = ALU_CLS_ADD;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op_q == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op_q == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_REG;
        alu_class = ALU_CLS_R;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        alu_class = ALU_CLS_I;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_REG;
        alu_class = ALU_CLS_SUB;
        case (funct3_q)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3_q),
    .funct7b5    (funct7b5_q),
    .alu_control (ALUControl)
  );

  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: each instruction pushes its per-cycle expected output bundle;
// a negedge monitor pops and compares one bundle per cycle.
module tb_multicycle_controller;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, JAL = 4'd9, LUI = 4'd10, BRANCH = 4'd11,
                         ILLEGAL = 4'd12;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcB, ALUSrcA;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] retired;
  logic [3:0] state_dbg;

  logic [25:0] exp_q[$];
  logic [3:0]  ret_m = '0;
  int          checks = 0;
  int          failures = 0;

  multicycle_controller #(.CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic [1:0] rs,
                                     input logic [2:0] alc, input logic [1:0] sb,
                                     input logic [1:0] sa, input logic [2:0] imm,
                                     input logic rw, input logic ill, input logic [3:0] ret);
    return {st, pcw, adr, mw, irw, rs, alc, sb, sa, imm, rw, ill, ret};
  endfunction

  function automatic logic [25:0] v_fetch(input logic [3:0] ret);
    return mk(FETCH, 1, 0, 0, 1, 2'b10, 3'b000, 2'b10, 2'b00, 3'b000, 0, 0, ret);
  endfunction

  function automatic logic [25:0] v_decode(input logic [2:0] imm, input logic [3:0] ret);
    return mk(DECODE, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, imm, 0, 0, ret);
  endfunction

  function automatic logic [25:0] v_aluwb(input logic [3:0] ret);
    return mk(ALUWB, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 1, 0, ret);
  endfunction

  // Monitor: one expected bundle per cycle while the scoreboard holds any.
  always @(negedge clk) begin
    logic [25:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
             ALUSrcB, ALUSrcA, ImmSrc, RegWrite, illegal, retired};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL out_bundle t=%0t state=%0d actual=%h expected=%h", $time, state_dbg, act, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic slot_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at the start of a FETCH cycle.
  task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    resetn   = 1'b1;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    exp_q.push_back(v_fetch(ret_m));
  endtask

  // Fields are scrambled after FETCH so only latched copies can decode correctly.
  task automatic finish(input int n, input bit inc);
    @(posedge clk);
    #1;
    op       = 7'b1111111;
    funct3   = ~funct3;
    funct7b5 = ~funct7b5;
    slot_wait(n - 1);
    if (inc) ret_m = ret_m + 4'd1;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    ret_m  = '0;
    repeat (n) exp_q.push_back(v_fetch(4'd0));
    slot_wait(n);
  endtask

  task automatic do_load();
    start(7'b0000011, 3'b010, 1'b0, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(MEMADR, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 3'b000, 0, 0, ret_m));
    exp_q.push_back(mk(MEMREAD, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 0, ret_m));
    exp_q.push_back(mk(MEMWB, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 1, 0, ret_m));
    finish(5, 1);
  endtask

  task automatic do_store();
    start(7'b0100011, 3'b010, 1'b0, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(MEMADR, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 3'b001, 0, 0, ret_m));
    exp_q.push_back(mk(MEMWRITE, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 0, ret_m));
    finish(4, 1);
  endtask

  task automatic do_r(input logic [2:0] f3, input logic f7, input logic [2:0] alc);
    start(7'b0110011, f3, f7, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(EXECR, 0, 0, 0, 0, 2'b00, alc, 2'b00, 2'b10, 3'b000, 0, 0, ret_m));
    exp_q.push_back(v_aluwb(ret_m));
    finish(4, 1);
  endtask

  task automatic do_i(input logic [2:0] f3, input logic f7, input logic [2:0] alc);
    start(7'b0010011, f3, f7, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(EXECI, 0, 0, 0, 0, 2'b00, alc, 2'b01, 2'b10, 3'b000, 0, 0, ret_m));
    exp_q.push_back(v_aluwb(ret_m));
    finish(4, 1);
  endtask

  task automatic do_branch(input logic [2:0] f3, input logic z, input logic pcw);
    start(7'b1100011, f3, 1'b0, z);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(BRANCH, pcw, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 3'b000, 0, 0, ret_m));
    finish(3, 1);
  endtask

  task automatic do_jal();
    start(7'b1101111, 3'b000, 1'b0, 1'b0);
    exp_q.push_back(v_decode(3'b011, ret_m));
    exp_q.push_back(mk(JAL, 1, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 3'b000, 0, 0, ret_m));
    exp_q.push_back(v_aluwb(ret_m));
    finish(4, 1);
  endtask

  task automatic do_lui();
    start(7'b0110111, 3'b000, 1'b0, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    exp_q.push_back(mk(LUI, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b11, 3'b100, 0, 0, ret_m));
    exp_q.push_back(v_aluwb(ret_m));
    finish(4, 1);
  endtask

  task automatic do_illegal(input logic [6:0] o);
    start(o, 3'b000, 1'b0, 1'b0);
    exp_q.push_back(v_decode(3'b010, ret_m));
    repeat (20)
      exp_q.push_back(mk(ILLEGAL, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 1, ret_m));
    finish(22, 0);
  endtask

  // Drops resetn mid-cycle in the third state after FETCH (MEMWRITE or ALUWB).
  task automatic do_async_reset(input bit store);
    if (store) begin
      start(7'b0100011, 3'b010, 1'b0, 1'b0);
      exp_q.push_back(v_decode(3'b010, ret_m));
      exp_q.push_back(mk(MEMADR, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 3'b001, 0, 0, ret_m));
    end else begin
      start(7'b0110011, 3'b000, 1'b1, 1'b0);
      exp_q.push_back(v_decode(3'b010, ret_m));
      exp_q.push_back(mk(EXECR, 0, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 3'b000, 0, 0, ret_m));
    end
    exp_q.push_back(v_fetch(4'd0));
    finish(3, 0);
    if (store) check("memwrite_before_reset", {31'd0, MemWrite}, 32'd1);
    else       check("regwrite_before_reset", {31'd0, RegWrite}, 32'd1);
    #2;
    resetn = 1'b0;
    ret_m  = '0;
    #1;
    check("memwrite_async_drop", {31'd0, MemWrite}, 32'd0);
    check("regwrite_async_drop", {31'd0, RegWrite}, 32'd0);
    check("state_async_reset", {28'd0, state_dbg}, {28'd0, FETCH});
    slot_wait(1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);
    do_load();
    do_r(3'b000, 1'b1, 3'b001);
    do_r(3'b000, 1'b0, 3'b000);
    do_i(3'b000, 1'b1, 3'b000);
    do_r(3'b010, 1'b0, 3'b101);
    do_i(3'b110, 1'b0, 3'b011);
    do_r(3'b111, 1'b1, 3'b010);
    do_i(3'b100, 1'b0, 3'b000);
    do_branch(3'b000, 1'b1, 1'b1);
    do_branch(3'b000, 1'b0, 1'b0);
    do_branch(3'b001, 1'b0, 1'b1);
    do_branch(3'b001, 1'b1, 1'b0);
    do_branch(3'b101, 1'b1, 1'b0);
    do_jal();
    do_lui();
    do_store();
    do_illegal(7'b1111111);
    do_reset(3);
    for (int i = 0; i < 16; i++) begin
      do_i(3'b000, 1'b0, 3'b000);
    end
    check("retired_wrap", {28'd0, retired}, 32'd0);
    do_load();
    check("retired_after_wrap", {28'd0, retired}, 32'd1);
    do_async_reset(1'b1);
    do_async_reset(1'b0);
    do_reset(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
